// File: rtl/sdram_cmd_sequencer.sv
// SDRAM command sequencer: power-up/init sequence, closed-page single-beat
// read/write accesses (ACT -> READ/WRIT -> PRE) and interval-driven auto-refresh.
// The state register always names the command being driven in the same cycle;
// cmd/cmd_ba/cmd_addr/wr_en are registered from the next-state decode.
module sdram_cmd_sequencer #(
   parameter int BANK_W   = 2,
   parameter int ROW_W    = 12,
   parameter int COL_W    = 9,
   parameter int T_PWR    = 8100,
   parameter int T_RP     = 2,
   parameter int T_RCD    = 2,
   parameter int T_RFC    = 7,
   parameter int CAS      = 2,
   parameter int T_REFI   = 400,
   parameter int INIT_REF = 2,
   parameter logic [ROW_W-1:0] MODE = 'h020,
   parameter int T_MRD    = 2
)(
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_req_valid,
   input  logic                          i_req_we,
   input  logic [BANK_W+ROW_W+COL_W-1:0] i_req_addr,
   output logic                          o_req_ready,
   output logic [3:0]                    o_cmd,
   output logic [BANK_W-1:0]             o_cmd_ba,
   output logic [ROW_W-1:0]              o_cmd_addr,
   output logic                          o_wr_en,
   output logic                          o_rd_valid,
   output logic                          o_init_done,
   output logic                          o_ref_overrun
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int MAX_T = max2(max2(max2(T_PWR, T_REFI), max2(T_RP, T_RCD)),
                               max2(max2(T_RFC, T_MRD), max2(CAS, INIT_REF)));
   localparam int CNT_W = $clog2(MAX_T) + 1;

   localparam logic [3:0] CMD_NOP  = 4'b0001;
   localparam logic [3:0] CMD_MRS  = 4'b0010;
   localparam logic [3:0] CMD_ACT  = 4'b0011;
   localparam logic [3:0] CMD_READ = 4'b0100;
   localparam logic [3:0] CMD_WRIT = 4'b0110;
   localparam logic [3:0] CMD_PRE  = 4'b1000;
   localparam logic [3:0] CMD_PALL = 4'b1001;
   localparam logic [3:0] CMD_REF  = 4'b1011;

   typedef enum logic [3:0] {
      S_POW, S_I_PALL, S_I_REF, S_I_MRS, S_IDLE, S_ACT, S_RW, S_PRE, S_REF, S_WAIT
   } state_t;

   state_t              r_state, r_ret, w_state_next, w_ret_next, w_after;
   logic [CNT_W-1:0]    r_cnt, w_cnt_next, r_iref_cnt, w_iref_next, w_delay;
   logic [CNT_W-1:0]    r_refi_cnt;
   logic                w_go, w_ref_clr, w_accept, w_refi_expire;
   logic [BANK_W-1:0]   r_bank, w_req_bank, w_ba_next;
   logic [ROW_W-1:0]    w_req_row, w_addr_next, w_col_addr;
   logic [COL_W-1:0]    r_col, w_req_col;
   logic                r_we, r_ref_due, w_wr_next;
   logic [3:0]          w_cmd_next;
   logic [CAS-1:0]      r_rd_pipe;

   assign w_req_bank = i_req_addr[BANK_W+ROW_W+COL_W-1 -: BANK_W];
   assign w_req_row  = i_req_addr[ROW_W+COL_W-1 -: ROW_W];
   assign w_req_col  = i_req_addr[COL_W-1:0];

   assign o_req_ready   = (r_state == S_IDLE) && !r_ref_due;
   assign o_rd_valid    = r_rd_pipe[CAS-1];
   assign w_refi_expire = o_init_done && (r_refi_cnt == '0);

   // Next-state decode; timed gaps go through WAIT (delay-2 down-count) unless the gap is zero
   always_comb begin
      w_state_next = r_state;
      w_ret_next   = r_ret;
      w_cnt_next   = r_cnt;
      w_iref_next  = r_iref_cnt;
      w_go         = 1'b0;
      w_delay      = '0;
      w_after      = S_IDLE;
      w_ref_clr    = 1'b0;
      w_accept     = 1'b0;
      case (r_state)
         S_POW: begin
            if (r_cnt == '0) w_state_next = S_I_PALL;
            else             w_cnt_next   = r_cnt - 1'b1;
         end
         S_I_PALL: begin
            w_go = 1'b1; w_delay = CNT_W'(T_RP); w_after = S_I_REF;
         end
         S_I_REF: begin
            w_go        = 1'b1;
            w_delay     = CNT_W'(T_RFC);
            w_iref_next = r_iref_cnt - 1'b1;
            w_after     = (r_iref_cnt == CNT_W'(1)) ? S_I_MRS : S_I_REF;
         end
         S_I_MRS: begin
            w_go = 1'b1; w_delay = CNT_W'(T_MRD); w_after = S_IDLE;
         end
         S_IDLE: begin
            if (r_ref_due) begin
               w_state_next = S_REF;
               w_ref_clr    = 1'b1;
            end else if (i_req_valid) begin
               w_state_next = S_ACT;
               w_accept     = 1'b1;
            end
         end
         S_ACT: begin
            w_go = 1'b1; w_delay = CNT_W'(T_RCD); w_after = S_RW;
         end
         S_RW:  w_state_next = S_PRE;
         S_PRE: begin
            w_go = 1'b1; w_delay = CNT_W'(T_RP); w_after = S_IDLE;
         end
         S_REF: begin
            w_go = 1'b1; w_delay = CNT_W'(T_RFC); w_after = S_IDLE;
         end
         S_WAIT: begin
            if (r_cnt == '0) w_state_next = r_ret;
            else             w_cnt_next   = r_cnt - 1'b1;
         end
         default: w_state_next = S_POW;
      endcase
      if (w_go) begin
         if (w_delay <= CNT_W'(1)) begin
            w_state_next = w_after;
         end else begin
            w_state_next = S_WAIT;
            w_cnt_next   = w_delay - CNT_W'(2);
            w_ret_next   = w_after;
         end
      end
   end

   // Command/address decode for the state being entered
   always_comb begin
      w_cmd_next      = CMD_NOP;
      w_ba_next       = '0;
      w_addr_next     = '0;
      w_wr_next       = 1'b0;
      w_col_addr      = ROW_W'(r_col);
      w_col_addr[10]  = 1'b0;
      case (w_state_next)
         S_I_PALL: begin
            w_cmd_next      = CMD_PALL;
            w_addr_next[10] = 1'b1;
         end
         S_I_REF, S_REF: w_cmd_next = CMD_REF;
         S_I_MRS: begin
            w_cmd_next  = CMD_MRS;
            w_addr_next = MODE;
         end
         S_ACT: begin
            w_cmd_next  = CMD_ACT;
            w_ba_next   = w_req_bank;
            w_addr_next = w_req_row;
         end
         S_RW: begin
            w_cmd_next  = r_we ? CMD_WRIT : CMD_READ;
            w_ba_next   = r_bank;
            w_addr_next = w_col_addr;
            w_wr_next   = r_we;
         end
         S_PRE: begin
            w_cmd_next = CMD_PRE;
            w_ba_next  = r_bank;
         end
         default: ;
      endcase
   end

   // FSM state, counters, latched request and registered command outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_POW;
         r_ret       <= S_IDLE;
         r_cnt       <= CNT_W'(T_PWR);
         r_iref_cnt  <= CNT_W'(INIT_REF);
         r_bank      <= '0;
         r_col       <= '0;
         r_we        <= 1'b0;
         o_cmd       <= CMD_NOP;
         o_cmd_ba    <= '0;
         o_cmd_addr  <= '0;
         o_wr_en     <= 1'b0;
         o_init_done <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_ret       <= w_ret_next;
         r_cnt       <= w_cnt_next;
         r_iref_cnt  <= w_iref_next;
         if (w_accept) begin
            r_bank <= w_req_bank;
            r_col  <= w_req_col;
            r_we   <= i_req_we;
         end
         o_cmd       <= w_cmd_next;
         o_cmd_ba    <= w_ba_next;
         o_cmd_addr  <= w_addr_next;
         o_wr_en     <= w_wr_next;
         o_init_done <= o_init_done || (w_state_next == S_IDLE);
      end
   end

   // CAS-deep read-data pipeline, loaded in the READ cycle
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_pipe <= '0;
      end else begin
         r_rd_pipe[0] <= (o_cmd == CMD_READ);
         for (int i = 1; i < CAS; i++) r_rd_pipe[i] <= r_rd_pipe[i-1];
      end
   end

   // Refresh interval timer: free-running once init is done, flags due/overrun
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_refi_cnt    <= CNT_W'(T_REFI - 2);
         r_ref_due     <= 1'b0;
         o_ref_overrun <= 1'b0;
      end else begin
         if (o_init_done) begin
            if (r_refi_cnt == '0) r_refi_cnt <= CNT_W'(T_REFI - 1);
            else                  r_refi_cnt <= r_refi_cnt - 1'b1;
         end
         if (w_refi_expire)  r_ref_due <= 1'b1;
         else if (w_ref_clr) r_ref_due <= 1'b0;
         o_ref_overrun <= o_ref_overrun || (w_refi_expire && r_ref_due);
      end
   end

endmodule
